// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
//   Shared definitions for the GPU drawing pipeline.
//   - rast_state_t   : line rasterizer FSM states (IDLE, SETUP, DRAW)
//   - SCREEN_W/H     : framebuffer geometry in pixels
//   - pixel_color_t  : 16-bit nibble-packed pixel colour (4-4-4-4)
//   - COLOR_BG/FG    : background / foreground colours for the framebuffer writer
// -----------------------------------------------------------------------------
package gpu_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } rast_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [3:0] a;
    } pixel_color_t;

    localparam pixel_color_t COLOR_BG = '{r: 4'h0, g: 4'h0, b: 4'h0, a: 4'hF};
    localparam pixel_color_t COLOR_FG = '{r: 4'hF, g: 4'hF, b: 4'hF, a: 4'hF};

endpackage

// File: rtl/line_addr_gen.sv
// -----------------------------------------------------------------------------
// line_addr_gen
//   Registers the framebuffer word address y*SCREEN_W + x (two's complement,
//   truncated to ADDR_W) for a signed pixel coordinate, together with a flag
//   telling whether the coordinate lies inside the visible screen.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   load       in   capture a new coordinate this cycle
//   x, y       in   signed pixel coordinate (COORD_W bits)
//   addr       out  registered word address (ADDR_W bits)
//   on_screen  out  registered: 0 <= x < SCREEN_W and 0 <= y < SCREEN_H
// -----------------------------------------------------------------------------
module line_addr_gen #(
    parameter int SCREEN_W = gpu_pkg::SCREEN_W,
    parameter int SCREEN_H = gpu_pkg::SCREEN_H,
    parameter int COORD_W  = 11,
    parameter int ADDR_W   = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic signed [COORD_W-1:0] x,
    input  logic signed [COORD_W-1:0] y,
    output logic        [ADDR_W-1:0]  addr,
    output logic                      on_screen
);

    logic signed [31:0] x_ext;
    logic signed [31:0] y_ext;
    logic [ADDR_W-1:0]  addr_calc;
    logic               visible;

    // NOTE: every variable written in always_comb gets a value on every path
    // (here unconditionally) so no latch can be inferred.
    always_comb begin
        x_ext     = 32'(x);
        y_ext     = 32'(y);
        // Negative coordinates wrap in two's complement before truncation.
        addr_calc = ADDR_W'(y_ext * SCREEN_W + x_ext);
        visible   = (x_ext >= 0) && (x_ext < SCREEN_W) &&
                    (y_ext >= 0) && (y_ext < SCREEN_H);
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            on_screen <= 1'b0;
        end else if (load) begin
            addr      <= addr_calc;
            on_screen <= visible;
        end
    end

endmodule

// File: rtl/line_rasterizer.sv
// -----------------------------------------------------------------------------
// line_rasterizer
//   Accepts line-draw commands (two signed endpoints plus a colour) and walks
//   the line with integer Bresenham stepping in all octants, emitting one
//   framebuffer pixel write (word address + data) per cycle over valid/ready.
//
//   Optional feature macro: LINE_RAST_CLIP_EN
//     defined   : off-screen pixels are stepped internally (one per cycle,
//                 O_PIX_VALID low, no handshake); fully off-screen lines emit
//                 nothing but still pulse O_DONE.
//     undefined : every pixel is presented; the address wraps in two's
//                 complement.
//
// Ports:
//   I_CLK, I_RST        clock, synchronous active-high reset
//   I_CMD_VALID         command present
//   O_CMD_READY         command can be accepted (IDLE only)
//   I_X0,I_Y0,I_X1,I_Y1 signed endpoints (COORD_W bits)
//   I_COLOR             pixel colour (COLOR_W bits)
//   O_PIX_VALID         pixel write present
//   I_PIX_READY         downstream accepts the pixel
//   O_PIX_ADDR          y*SCREEN_W + x truncated to ADDR_W
//   O_PIX_DATA          latched command colour
//   O_BUSY              high in SETUP or DRAW
//   O_DONE              one-cycle pulse after the last pixel of a line
// -----------------------------------------------------------------------------
module line_rasterizer #(
    parameter int SCREEN_W = gpu_pkg::SCREEN_W,
    parameter int SCREEN_H = gpu_pkg::SCREEN_H,
    parameter int COORD_W  = 11,
    parameter int ADDR_W   = 18,
    parameter int COLOR_W  = 16
) (
    input  logic                      I_CLK,
    input  logic                      I_RST,
    input  logic                      I_CMD_VALID,
    output logic                      O_CMD_READY,
    input  logic signed [COORD_W-1:0] I_X0,
    input  logic signed [COORD_W-1:0] I_Y0,
    input  logic signed [COORD_W-1:0] I_X1,
    input  logic signed [COORD_W-1:0] I_Y1,
    input  logic        [COLOR_W-1:0] I_COLOR,
    output logic                      O_PIX_VALID,
    input  logic                      I_PIX_READY,
    output logic        [ADDR_W-1:0]  O_PIX_ADDR,
    output logic        [COLOR_W-1:0] O_PIX_DATA,
    output logic                      O_BUSY,
    output logic                      O_DONE
);

    import gpu_pkg::*;

    // Delta, error term and doubled error widths; sized so that no legal
    // COORD_W endpoint pair can overflow them.
    localparam int DW  = COORD_W + 1;
    localparam int EW  = COORD_W + 2;
    localparam int E2W = COORD_W + 3;

    rast_state_t               state;
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] x_end;
    logic signed [COORD_W-1:0] y_end;
    logic signed [DW-1:0]      dx;      // +|x1-x0|
    logic signed [DW-1:0]      dy;      // -|y1-y0|
    logic                      x_neg;   // sx == -1
    logic                      y_neg;   // sy == -1
    logic signed [EW-1:0]      err;
    logic        [COLOR_W-1:0] color;
    logic                      done;

    // Setup-cycle values, derived from the latched endpoints (x,y hold x0,y0).
    logic signed [DW-1:0]      dx_raw;
    logic signed [DW-1:0]      dy_raw;
    logic signed [DW-1:0]      dx_abs;
    logic signed [DW-1:0]      dy_abs;
    logic signed [EW-1:0]      err_init;

    // Bresenham step, computed from the pre-update error term.
    logic signed [E2W-1:0]     e2;
    logic                      x_step;
    logic                      y_step;
    logic signed [EW-1:0]      err_dx_term;
    logic signed [EW-1:0]      err_dy_term;
    logic signed [EW-1:0]      err_next;
    logic signed [COORD_W-1:0] sx_val;
    logic signed [COORD_W-1:0] sy_val;
    logic signed [COORD_W-1:0] x_next;
    logic signed [COORD_W-1:0] y_next;

    logic                      at_end;
    logic                      pix_valid;
    logic                      advance;
    logic                      addr_load;
    logic signed [COORD_W-1:0] addr_x;
    logic signed [COORD_W-1:0] addr_y;
    logic                      on_screen;

    always_comb begin
        dx_raw   = DW'(x_end) - DW'(x);
        dy_raw   = DW'(y_end) - DW'(y);
        dx_abs   = (dx_raw < 0) ? -dx_raw : dx_raw;
        dy_abs   = (dy_raw < 0) ? -dy_raw : dy_raw;
        err_init = EW'(dx_abs) - EW'(dy_abs);
    end

    always_comb begin
        e2          = E2W'(err) <<< 1;
        x_step      = (e2 >= E2W'(dy));
        y_step      = (e2 <= E2W'(dx));
        err_dy_term = x_step ? EW'(dy) : EW'(0);
        err_dx_term = y_step ? EW'(dx) : EW'(0);
        err_next    = err + err_dy_term + err_dx_term;
        sx_val      = x_neg ? {COORD_W{1'b1}} : COORD_W'(1);
        sy_val      = y_neg ? {COORD_W{1'b1}} : COORD_W'(1);
        x_next      = x_step ? (x + sx_val) : x;
        y_next      = y_step ? (y + sy_val) : y;
    end

    assign at_end = (x == x_end) && (y == y_end);

`ifdef LINE_RAST_CLIP_EN
    // Off-screen pixels are never offered downstream.
    assign pix_valid = (state == DRAW) && on_screen;
`else
    assign pix_valid = (state == DRAW);
    // The visibility flag only matters when clipping is built in.
    logic unused_on_screen;
    assign unused_on_screen = on_screen;
`endif

    // A DRAW step happens on handshake, or freely for a suppressed pixel.
    assign advance = (state == DRAW) && (pix_valid ? I_PIX_READY : 1'b1);

    // The address generator is loaded with the pixel that will be current in
    // the next cycle, so its registered address lines up with (x,y).
    assign addr_load = (state == SETUP) || (advance && !at_end);
    assign addr_x    = (state == SETUP) ? x : x_next;
    assign addr_y    = (state == SETUP) ? y : y_next;

    line_addr_gen #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .COORD_W  (COORD_W),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk       (I_CLK),
        .rst       (I_RST),
        .load      (addr_load),
        .x         (addr_x),
        .y         (addr_y),
        .addr      (O_PIX_ADDR),
        .on_screen (on_screen)
    );

    // NOTE: the datapath registers are reset along with the FSM; there is no
    // memory array here, so a full reset is cheap and keeps outputs defined.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            x_end <= '0;
            y_end <= '0;
            dx    <= '0;
            dy    <= '0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
            err   <= '0;
            color <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_CMD_VALID) begin
                        x     <= I_X0;
                        y     <= I_Y0;
                        x_end <= I_X1;
                        y_end <= I_Y1;
                        color <= I_COLOR;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dx    <= dx_abs;
                    dy    <= -dy_abs;
                    x_neg <= !(x < x_end);
                    y_neg <= !(y < y_end);
                    err   <= err_init;
                    state <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (at_end) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            x   <= x_next;
                            y   <= y_next;
                            err <= err_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign O_CMD_READY = (state == IDLE);
    assign O_BUSY      = (state != IDLE);
    assign O_DONE      = done;
    assign O_PIX_VALID = pix_valid;
    assign O_PIX_DATA  = color;

endmodule

// File: tb/tb_line_rasterizer.sv
// -----------------------------------------------------------------------------
// tb_line_rasterizer
//   Directed scoreboard bench for line_rasterizer. Stimulus pushes the
//   hand-computed pixel stream into a queue; a negedge monitor compares every
//   presented pixel against the queue head and pops it on handshake.
// -----------------------------------------------------------------------------
module tb_line_rasterizer;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [10:0] x0, y0, x1, y1;
    logic        [15:0] color;
    logic               pix_valid;
    logic               pix_ready;
    logic        [17:0] pix_addr;
    logic        [15:0] pix_data;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    line_rasterizer dut (
        .I_CLK       (clk),
        .I_RST       (rst),
        .I_CMD_VALID (cmd_valid),
        .O_CMD_READY (cmd_ready),
        .I_X0        (x0),
        .I_Y0        (y0),
        .I_X1        (x1),
        .I_Y1        (y1),
        .I_COLOR     (color),
        .O_PIX_VALID (pix_valid),
        .I_PIX_READY (pix_ready),
        .O_PIX_ADDR  (pix_addr),
        .O_PIX_DATA  (pix_data),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   last_hs_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic push(input int addr, input logic [15:0] data);
        exp_t e;
        e.addr = addr[17:0];
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: while a pixel is presented it must match the queue head
    // (so it is also held stable under backpressure); pop on handshake.
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_extra: got addr %0d, expected no pixel (cycle %0d)",
                         pix_addr, cyc);
            end else begin
                check("pix_addr", pix_addr, sb[0].addr);
                check("pix_data", pix_data, sb[0].data);
                if (pix_ready) begin
                    void'(sb.pop_front());
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    // Called aligned to a negedge; returns one cycle after the accept edge.
    task automatic issue_cmd(input logic signed [10:0] ax0, ay0, ax1, ay1,
                             input logic [15:0] col);
        bit accepted = 1'b0;
        @(posedge clk);
        #1;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = col;
        cmd_valid = 1'b1;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (cmd_ready) accepted = 1'b1;
            @(posedge clk);
            if (accepted) break;
        end
        #1;
        cmd_valid = 1'b0;
        check("cmd_accept", accepted, 1'b1);
    endtask

    // Runs one line to completion. exp_lat < 0 skips the first-valid latency
    // check; ready is dropped for cycles [stall_start, stall_start+stall_len).
    task automatic run_line(input logic signed [10:0] ax0, ay0, ax1, ay1,
                            input logic [15:0] col, input int exp_lat,
                            input int stall_start, input int stall_len,
                            input bit check_done_lat);
        bit seen_valid = 1'b0;
        bit got_done   = 1'b0;
        bit stalling;
        issue_cmd(ax0, ay0, ax1, ay1, col);
        for (int k = 1; k <= 300; k++) begin
            stalling  = (k >= stall_start) && (k < stall_start + stall_len);
            pix_ready = !stalling;
            @(negedge clk);
            if (k == 1) begin
                check("setup_busy", busy, 1'b1);
                check("setup_cmd_ready", cmd_ready, 1'b0);
            end
            if (stalling) begin
                check("stall_valid_held", pix_valid, 1'b1);
                check("stall_cmd_ready", cmd_ready, 1'b0);
            end
            if (!seen_valid && pix_valid) begin
                seen_valid = 1'b1;
                if (exp_lat >= 0) check("first_valid_lat", k, exp_lat);
            end
            if (done) begin
                got_done = 1'b1;
                if (check_done_lat) check("done_lat", cyc, last_hs_cyc + 1);
                check("done_cmd_ready", cmd_ready, 1'b1);
                check("done_busy", busy, 1'b0);
                break;
            end
            @(posedge clk);
            #1;
        end
        pix_ready = 1'b1;
        check("done_seen", got_done, 1'b1);
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        check("done_pulse_width", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_after_rst;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        pix_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        color = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_pix_data", pix_data, 0);

        // Horizontal line (0,0)->(3,0).
        for (int i = 0; i < 4; i++) push(i, 16'hFFFF);
        run_line(0, 0, 3, 0, 16'hFFFF, 2, 0, 0, 1'b1);

        // Reversed (3,0)->(0,0).
        for (int i = 3; i >= 0; i--) push(i, 16'hA5C3);
        run_line(3, 0, 0, 0, 16'hA5C3, 2, 0, 0, 1'b1);

        // Steep negative-x (10,10)->(8,14).
        push(6410, 16'h0F0F);
        push(7049, 16'h0F0F);
        push(7689, 16'h0F0F);
        push(8328, 16'h0F0F);
        push(8968, 16'h0F0F);
        run_line(10, 10, 8, 14, 16'h0F0F, 2, 0, 0, 1'b1);

        // Single point (5,5).
        push(3205, 16'h1234);
        run_line(5, 5, 5, 5, 16'h1234, 2, 0, 0, 1'b1);

        // Backpressure: ready low for 3 cycles on the second pixel.
        for (int i = 0; i < 4; i++) push(i, 16'hBEEF);
        run_line(0, 0, 3, 0, 16'hBEEF, 2, 3, 3, 1'b1);

        // Clipping (-2,5)->(1,5).
`ifdef LINE_RAST_CLIP_EN
        push(3200, 16'hC0DE);
        push(3201, 16'hC0DE);
        run_line(-2, 5, 1, 5, 16'hC0DE, 4, 0, 0, 1'b1);
        // Fully off-screen line: no pixels, still a done pulse.
        run_line(-5, -5, -1, -1, 16'hC0DE, -1, 0, 0, 1'b0);
`else
        push(3198, 16'hC0DE);
        push(3199, 16'hC0DE);
        push(3200, 16'hC0DE);
        push(3201, 16'hC0DE);
        run_line(-2, 5, 1, 5, 16'hC0DE, 2, 0, 0, 1'b1);
`endif

        // Reset mid-line (0,0)->(10,0): pixels 0..3 handshake in cycles
        // N+2..N+5, reset applied at the end of N+5.
        for (int i = 0; i < 4; i++) push(i, 16'h5A5A);
        issue_cmd(0, 0, 10, 0, 16'h5A5A);
        pix_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_pix_valid", pix_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        check("midrst_pix_addr", pix_addr, 0);
        done_after_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_after_rst = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_done", done_after_rst, 1'b0);
        check("midrst_sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_rasterizer.md
# line_rasterizer

Upstream drawing stage of the GPU: accepts line-draw commands (two endpoints plus a 16-bit colour) and walks the line with integer Bresenham stepping across all octants. It emits one framebuffer pixel write per cycle as an SRAM word address plus data, over a valid/ready handshake. The framebuffer writer that drives the GPU-SRAM port consumes this stream and forwards each accepted pixel as an SRAM write.

## Interface
Parameters:
- SCREEN_W, 640, framebuffer width in pixels (row pitch for address computation)
- SCREEN_H, 400, framebuffer height in pixels
- COORD_W, 11, signed two's-complement coordinate width
- ADDR_W, 18, SRAM word address width
- COLOR_W, 16, pixel data width (4-4-4-4 nibbles)

Ports:
- I_CLK  in  1  clock; all logic on rising edge
- I_RST  in  1  synchronous, active-high reset
- I_CMD_VALID  in  1  command present
- O_CMD_READY  out  1  block can accept a command (high only in IDLE)
- I_X0, I_Y0, I_X1, I_Y1  in  COORD_W each  signed endpoints
- I_COLOR  in  COLOR_W  pixel data
- O_PIX_VALID  out  1  pixel write present
- I_PIX_READY  in  1  downstream accepts pixel
- O_PIX_ADDR  out  ADDR_W  y*SCREEN_W + x, truncated to ADDR_W
- O_PIX_DATA  out  COLOR_W  latched command colour
- O_BUSY  out  1  high in SETUP or DRAW
- O_DONE  out  1  one-cycle pulse when a line completes

## Operation
- FSM: IDLE -> SETUP -> DRAW -> IDLE.
- IDLE: O_CMD_READY=1. If I_CMD_VALID is high, latch endpoints and colour, then go to SETUP.
- SETUP (one cycle): compute the following and go to DRAW.
  - dx=|x1-x0|, dy=-|y1-y0|
  - sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1
  - err=dx+dy; x=x0, y=y0
- DRAW: present the current (x,y). A step happens on handshake (O_PIX_VALID & I_PIX_READY).
  - If x==x1 && y==y1: go to IDLE and pulse O_DONE next cycle.
  - Otherwise, with e2=2*err computed from the pre-update err:
    - if e2>=dy: err+=dy, x+=sx
    - if e2<=dx: err+=dx, y+=sy
    - Both updates may apply in the same step.
- Widths: dx and dy use COORD_W+1 bits signed; err uses COORD_W+2; e2 uses COORD_W+3. No overflow is permitted for any legal COORD_W input.
- Pixel count is max(|x1-x0|,|y1-y0|)+1. A degenerate point (x0==x1, y0==y1) produces exactly one pixel.
- O_PIX_ADDR and O_PIX_DATA are registered and held stable while O_PIX_VALID=1 and I_PIX_READY=0. O_PIX_VALID never drops without a handshake, except on reset.
- Reset mid-operation: go to IDLE immediately; drop O_PIX_VALID; no O_DONE pulse; the partial line is abandoned.

## Timing
- Reset values:
  - state=IDLE, O_CMD_READY=1, O_PIX_VALID=0, O_BUSY=0, O_DONE=0
  - O_PIX_ADDR=0, O_PIX_DATA=0
- Command accepted in cycle N: SETUP in N+1; first O_PIX_VALID in N+2.
- With I_PIX_READY held high, the block sustains one pixel per cycle.
- Last handshake in cycle M: O_DONE=1 and O_CMD_READY=1 in M+1. The earliest next accept is M+1.
- O_BUSY is high from N+1 through M inclusive.

## Configuration
- LINE_RAST_CLIP_EN defined:
  - Pixels with x outside [0,SCREEN_W-1] or y outside [0,SCREEN_H-1] are stepped internally, one per cycle, with O_PIX_VALID=0. No handshake is required for them.
  - A line that is fully off-screen emits zero pixels and still pulses O_DONE.
- LINE_RAST_CLIP_EN undefined:
  - Every pixel is presented.
  - Address is y*SCREEN_W+x in two's complement, truncated to ADDR_W.

## Structure
- Shared package gpu_pkg holds:
  - the FSM state enum (IDLE, SETUP, DRAW)
  - SCREEN_W and SCREEN_H constants
  - the pixel colour typedef (16-bit nibble-packed)
  - the background and foreground colour constants used by the framebuffer writer
- Sub-module line_addr_gen: registered (x,y) to y*SCREEN_W+x address, plus the on-screen flag used for clipping.

## Test plan
- Horizontal line (0,0)->(3,0), colour FFFF, ready=1 -> first valid 2 cycles after accept; addrs 0,1,2,3 on consecutive cycles; O_DONE one cycle after addr 3.
- Reversed line (3,0)->(0,0) -> addrs 3,2,1,0.
- Steep negative-x line (10,10)->(8,14) -> pixels (10,10),(9,11),(9,12),(8,13),(8,14); addrs 6410,7049,7689,8328,8968.
- Single point (5,5)->(5,5) -> exactly one pixel at addr 3205, then O_DONE.
- Backpressure on (0,0)->(3,0): I_PIX_READY low for 3 cycles at the second pixel -> addr 1 and data held stable; total 4 handshakes; O_CMD_READY stays 0 until done.
- Clipping (-2,5)->(1,5):
  - with LINE_RAST_CLIP_EN -> addrs 3200,3201 only.
  - without it -> 3198,3199,3200,3201.
  - I_RST asserted mid-line -> O_PIX_VALID=0 next cycle, no O_DONE pulse.
